// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared state encoding, widths and sizing helper for the PLL reset controller
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ASSERT_RST = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } pll_state_t;

  localparam int LOSS_CNT_W = 8;

  // Width needed for a counter that only ever reaches (largest limit - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - multi-flop synchronizer for the asynchronous PLL lock indication
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  // Shift the raw lock level through the chain; resets to "not locked".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset/lock sequencer with retries; define PLL_LOSS_COUNT_EN for the lock-loss counter
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 20,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int SYNC_STAGES         = 2
) (
  input  logic                               refclk,
  input  logic                               rst_n,
  input  logic                               locked_i,
  input  logic                               restart,
  output logic                               pll_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [LOSS_CNT_W-1:0]              loss_count
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  pll_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry_nxt;
  logic          lock_lost_nxt;
  logic          locked_s;

  pll_lock_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked_i),
    .q     (locked_s)
  );

  // State, shared cycle counter and status flags; outputs decoded from the next state so they stay registered.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ASSERT_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lock_lost_nxt;
      pll_rst   <= (state_nxt == ASSERT_RST);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      fault     <= (state_nxt == FAULT);
    end
  end

  // Next-state logic: restart overrides everything, otherwise walk pulse -> wait -> stable -> run.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    retry_nxt     = retry_cnt;
    lock_lost_nxt = lock_lost;

    if (restart) begin
      state_nxt     = ASSERT_RST;
      cnt_nxt       = '0;
      retry_nxt     = '0;
      lock_lost_nxt = 1'b0;
    end else begin
      case (state)
        ASSERT_RST: begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == PULSE_LAST) begin
            state_nxt = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          cnt_nxt = cnt + CW'(1);
          if (locked_s) begin
            state_nxt = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = FAULT;
            end else begin
              retry_nxt = retry_cnt + RW'(1);
              state_nxt = ASSERT_RST;
            end
          end
        end
        STABLE: begin
          cnt_nxt = cnt + CW'(1);
          if (!locked_s) begin
            state_nxt = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_nxt = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_nxt     = ASSERT_RST;
            lock_lost_nxt = 1'b1;
            retry_nxt     = '0;
          end
        end
        FAULT: begin
          state_nxt = FAULT;
        end
        default: begin
          state_nxt = ASSERT_RST;
        end
      endcase
    end

    // Every state measures its own dwell time from zero.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic loss_evt;

  assign loss_evt = (state == RUN) && !locked_s && !restart;

  // Saturating count of lock losses seen in RUN; only rst_n clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_count <= '0;
    end else if (loss_evt && (loss_count != '1)) begin
      loss_count <= loss_count + LOSS_CNT_W'(1);
    end
  end
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

  localparam int RP = 4;
  localparam int LT = 100;
  localparam int LS = 16;
  localparam int MR = 2;
  localparam int SS = 2;
  localparam int RW = $clog2(MR + 1);

`ifdef PLL_LOSS_COUNT_EN
  localparam int LC_EN = 1;
`else
  localparam int LC_EN = 0;
`endif

  logic          refclk;
  logic          rst_n;
  logic          locked_i;
  logic          restart;
  logic          pll_rst;
  logic          sys_rst_n;
  logic          ready;
  logic          fault;
  logic          lock_lost;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    loss_count;

  int total;
  int bad;

  typedef struct {
    int adv;
    bit lk;
    bit rs;
    bit e_pll;
    bit e_flt;
    int e_rty;
  } vec_t;

  vec_t tbl[15];

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .LOCK_STABLE_CYCLES  (LS),
    .MAX_RETRIES         (MR),
    .SYNC_STAGES         (SS)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .locked_i   (locked_i),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .retry_cnt  (retry_cnt),
    .loss_count (loss_count)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Edges until sys_rst_n reaches lvl (bounded).
  task automatic wait_sys(input logic lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sys_rst_n !== lvl && n < 200);
  endtask

  // Consecutive negedge samples with pll_rst high, starting now (bounded).
  task automatic count_hi(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    bit seen_hi;
    total = 0;
    bad   = 0;

    // Timeout/retry/fault/restart timeline; row 0 is the negedge right after a restart edge.
    tbl[0]  = '{0,  0, 0, 1, 0, 0};
    tbl[1]  = '{3,  0, 0, 1, 0, 0};
    tbl[2]  = '{1,  0, 0, 0, 0, 0};
    tbl[3]  = '{99, 0, 0, 0, 0, 0};
    tbl[4]  = '{1,  0, 0, 1, 0, 1};
    tbl[5]  = '{3,  0, 0, 1, 0, 1};
    tbl[6]  = '{1,  0, 0, 0, 0, 1};
    tbl[7]  = '{99, 0, 0, 0, 0, 1};
    tbl[8]  = '{1,  0, 0, 1, 0, 2};
    tbl[9]  = '{3,  0, 0, 1, 0, 2};
    tbl[10] = '{1,  0, 0, 0, 0, 2};
    tbl[11] = '{99, 0, 0, 0, 0, 2};
    tbl[12] = '{1,  0, 0, 0, 1, 2};
    tbl[13] = '{50, 0, 0, 0, 1, 2};
    tbl[14] = '{1,  0, 1, 1, 0, 0};

    rst_n    = 1'b0;
    locked_i = 1'b0;
    restart  = 1'b0;
    repeat (3) step();

    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst_n", sys_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_loss", loss_count, 0);

    // Nominal bring-up.
    rst_n = 1'b1;
    count_hi(n);
    chk("nom_pulse_len", n, RP);
    chk("nom_sys_before", sys_rst_n, 0);
    repeat (30) step();
    locked_i = 1'b1;
    wait_sys(1'b1, n);
    chk("nom_release_lat", n, SS + 1 + LS);
    chk("nom_ready", ready, 1);
    chk("nom_pll_rst", pll_rst, 0);
    chk("nom_retry", retry_cnt, 0);
    chk("nom_lock_lost", lock_lost, 0);

    // Lock loss in RUN.
    repeat (5) step();
    locked_i = 1'b0;
    wait_sys(1'b0, n);
    chk("loss_lat", n, SS + 1);
    chk("loss_ready", ready, 0);
    chk("loss_lock_lost", lock_lost, 1);
    chk("loss_count1", loss_count, LC_EN);
    count_hi(n);
    chk("loss_pulse_len", n, RP);

    // Glitch during STABLE at stable count 10.
    locked_i = 1'b1;
    seen_hi  = 1'b0;
    repeat (13) begin
      step();
      if (sys_rst_n) seen_hi = 1'b1;
    end
    locked_i = 1'b0;
    repeat (3) begin
      step();
      if (sys_rst_n) seen_hi = 1'b1;
    end
    locked_i = 1'b1;
    chk("glitch_no_release", seen_hi, 0);
    wait_sys(1'b1, n);
    chk("glitch_release_lat", n, SS + 1 + LS);
    chk("glitch_lock_lost_sticky", lock_lost, 1);

    // Second loss, then restart mid-STABLE.
    locked_i = 1'b0;
    wait_sys(1'b0, n);
    chk("loss2_lat", n, SS + 1);
    chk("loss_count2", loss_count, 2 * LC_EN);
    count_hi(n);
    chk("loss2_pulse_len", n, RP);
    locked_i = 1'b1;
    repeat (8) step();
    chk("mid_stable_sys", sys_rst_n, 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_stable_pll_rst", pll_rst, 1);
    chk("rs_stable_lock_lost", lock_lost, 0);
    chk("rs_stable_retry", retry_cnt, 0);
    chk("rs_stable_sys", sys_rst_n, 0);
    chk("rs_stable_loss_kept", loss_count, 2 * LC_EN);

    // Timeout, retries, FAULT and restart from FAULT.
    for (int i = 0; i < 15; i++) begin
      locked_i = tbl[i].lk;
      restart  = tbl[i].rs;
      for (int k = 0; k < tbl[i].adv; k++) begin
        step();
        restart = 1'b0;
      end
      chk($sformatf("tbl%0d_pll_rst", i), pll_rst, tbl[i].e_pll);
      chk($sformatf("tbl%0d_fault", i), fault, tbl[i].e_flt);
      chk($sformatf("tbl%0d_retry", i), retry_cnt, tbl[i].e_rty);
      chk($sformatf("tbl%0d_sys", i), sys_rst_n, 0);
      chk($sformatf("tbl%0d_lock_lost", i), lock_lost, 0);
    end
    chk("fault_loss_kept", loss_count, 2 * LC_EN);
    repeat (4) step();
    chk("after_fault_pll_rst", pll_rst, 0);

    // Reach RUN, then assert rst_n between edges.
    locked_i = 1'b1;
    wait_sys(1'b1, n);
    chk("rerun_release_lat", n, SS + 1 + LS);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst", pll_rst, 1);
    chk("async_sys_rst_n", sys_rst_n, 0);
    chk("async_ready", ready, 0);
    chk("async_loss_count", loss_count, 0);
    chk("async_retry", retry_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
